// File: rtl/riscv_instr_enc_if.sv
// Handshake and field bundle for the RV32I instruction encoder.
// The master drives requests and out_ready; the slave is the encoder.
interface riscv_instr_enc_if #(
    parameter int ERR_CNT_W = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic [2:0]           fmt;
    logic [6:0]           opcode;
    logic [4:0]           rd;
    logic [4:0]           rs1;
    logic [4:0]           rs2;
    logic [2:0]           funct3;
    logic [6:0]           funct7;
    logic [31:0]          imm;
    logic                 out_valid;
    logic                 out_ready;
    logic [31:0]          instr;
    logic                 imm_err;
    logic                 fmt_err;
    logic [ERR_CNT_W-1:0] err_cnt;

    modport master (
        output in_valid, fmt, opcode, rd, rs1, rs2, funct3, funct7, imm, out_ready,
        input  in_ready, out_valid, instr, imm_err, fmt_err, err_cnt
    );

    modport slave (
        input  in_valid, fmt, opcode, rd, rs1, rs2, funct3, funct7, imm, out_ready,
        output in_ready, out_valid, instr, imm_err, fmt_err, err_cnt
    );
endinterface

// File: rtl/riscv_instr_enc.sv
// RV32I instruction encoder: packs fields and immediate into R/I/S/B/U/J words
// through a two-stage valid/ready pipeline, flagging unrepresentable immediates.
module riscv_instr_enc #(
    parameter int CHECK_IMM = 1,
    parameter int ERR_CNT_W = 8
) (
    input  logic clk,
    input  logic aresetn,
    riscv_instr_enc_if.slave bus
);
    localparam logic [2:0] FMT_R = 3'd0;
    localparam logic [2:0] FMT_I = 3'd1;
    localparam logic [2:0] FMT_S = 3'd2;
    localparam logic [2:0] FMT_B = 3'd3;
    localparam logic [2:0] FMT_U = 3'd4;
    localparam logic [2:0] FMT_J = 3'd5;

    logic                 s1_valid_reg;
    logic [2:0]           s1_fmt_reg;
    logic [6:0]           s1_opcode_reg;
    logic [4:0]           s1_rd_reg;
    logic [4:0]           s1_rs1_reg;
    logic [4:0]           s1_rs2_reg;
    logic [2:0]           s1_funct3_reg;
    logic [6:0]           s1_funct7_reg;
    logic [31:0]          s1_imm_reg;

    logic                 s2_valid_reg;
    logic [31:0]          instr_reg;
    logic                 imm_err_reg;
    logic                 fmt_err_reg;
    logic [ERR_CNT_W-1:0] err_cnt_reg;

    logic                 s1_load;
    logic                 s2_load;
    logic [31:0]          instr_next;
    logic                 imm_bad_next;
    logic                 fmt_err_next;

    // Sign-extension checks: the dropped upper bits must all copy the top kept bit.
    logic i_bad;
    logic b_bad;
    logic j_bad;
    logic u_bad;

    assign s2_load = !s2_valid_reg || bus.out_ready;
    assign s1_load = !s1_valid_reg || s2_load;

    assign i_bad = !((&s1_imm_reg[31:11]) || !(|s1_imm_reg[31:11]));
    assign b_bad = s1_imm_reg[0] || !((&s1_imm_reg[31:12]) || !(|s1_imm_reg[31:12]));
    assign j_bad = s1_imm_reg[0] || !((&s1_imm_reg[31:20]) || !(|s1_imm_reg[31:20]));
    assign u_bad = |s1_imm_reg[11:0];

    always_comb begin
        instr_next   = 32'h0000_0000;
        imm_bad_next = 1'b0;
        fmt_err_next = 1'b0;
        case (s1_fmt_reg)
            FMT_R: instr_next = {s1_funct7_reg, s1_rs2_reg, s1_rs1_reg, s1_funct3_reg,
                                 s1_rd_reg, s1_opcode_reg};
            FMT_I: begin
                instr_next   = {s1_imm_reg[11:0], s1_rs1_reg, s1_funct3_reg,
                                s1_rd_reg, s1_opcode_reg};
                imm_bad_next = i_bad;
            end
            FMT_S: begin
                instr_next   = {s1_imm_reg[11:5], s1_rs2_reg, s1_rs1_reg, s1_funct3_reg,
                                s1_imm_reg[4:0], s1_opcode_reg};
                imm_bad_next = i_bad;
            end
            FMT_B: begin
                instr_next   = {s1_imm_reg[12], s1_imm_reg[10:5], s1_rs2_reg, s1_rs1_reg,
                                s1_funct3_reg, s1_imm_reg[4:1], s1_imm_reg[11], s1_opcode_reg};
                imm_bad_next = b_bad;
            end
            FMT_U: begin
                instr_next   = {s1_imm_reg[31:12], s1_rd_reg, s1_opcode_reg};
                imm_bad_next = u_bad;
            end
            FMT_J: begin
                instr_next   = {s1_imm_reg[20], s1_imm_reg[10:1], s1_imm_reg[11],
                                s1_imm_reg[19:12], s1_rd_reg, s1_opcode_reg};
                imm_bad_next = j_bad;
            end
            default: fmt_err_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            s1_valid_reg  <= 1'b0;
            s1_fmt_reg    <= 3'd0;
            s1_opcode_reg <= 7'd0;
            s1_rd_reg     <= 5'd0;
            s1_rs1_reg    <= 5'd0;
            s1_rs2_reg    <= 5'd0;
            s1_funct3_reg <= 3'd0;
            s1_funct7_reg <= 7'd0;
            s1_imm_reg    <= 32'd0;
        end else if (s1_load) begin
            s1_valid_reg <= bus.in_valid;
            if (bus.in_valid) begin
                s1_fmt_reg    <= bus.fmt;
                s1_opcode_reg <= bus.opcode;
                s1_rd_reg     <= bus.rd;
                s1_rs1_reg    <= bus.rs1;
                s1_rs2_reg    <= bus.rs2;
                s1_funct3_reg <= bus.funct3;
                s1_funct7_reg <= bus.funct7;
                s1_imm_reg    <= bus.imm;
            end
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            s2_valid_reg <= 1'b0;
            instr_reg    <= 32'd0;
            imm_err_reg  <= 1'b0;
            fmt_err_reg  <= 1'b0;
        end else if (s2_load) begin
            s2_valid_reg <= s1_valid_reg;
            if (s1_valid_reg) begin
                instr_reg   <= instr_next;
                imm_err_reg <= (CHECK_IMM != 0) && imm_bad_next;
                fmt_err_reg <= fmt_err_next;
            end
        end
    end

    // Counts only words that actually leave; saturates instead of wrapping.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            err_cnt_reg <= '0;
        end else if (s2_valid_reg && bus.out_ready && (imm_err_reg || fmt_err_reg)
                     && (err_cnt_reg != {ERR_CNT_W{1'b1}})) begin
            err_cnt_reg <= err_cnt_reg + 1'b1;
        end
    end

    assign bus.in_ready  = s1_load;
    assign bus.out_valid = s2_valid_reg;
    assign bus.instr     = instr_reg;
    assign bus.imm_err   = imm_err_reg;
    assign bus.fmt_err   = fmt_err_reg;
    assign bus.err_cnt   = err_cnt_reg;
endmodule

// File: tb/tb_riscv_instr_enc.sv
// Directed bench for riscv_instr_enc: formats, errors, backpressure, saturation, reset.
module tb_riscv_instr_enc;
    logic clk = 1'b0;
    logic aresetn = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    riscv_instr_enc_if #(.ERR_CNT_W(8)) bus1 ();
    riscv_instr_enc_if #(.ERR_CNT_W(2)) bus2 ();

    riscv_instr_enc #(.CHECK_IMM(1), .ERR_CNT_W(8)) dut (
        .clk(clk), .aresetn(aresetn), .bus(bus1.slave)
    );
    riscv_instr_enc #(.CHECK_IMM(0), .ERR_CNT_W(2)) dut_sat (
        .clk(clk), .aresetn(aresetn), .bus(bus2.slave)
    );

    typedef struct {
        logic [2:0]  fmt;
        logic [6:0]  opc;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
        logic [31:0] ins;
        logic        ie;
        logic        fe;
    } vec_t;

    vec_t v [10];
    vec_t w [6];
    vec_t va, vb, vc;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic drive1(input vec_t x);
        bus1.fmt = x.fmt; bus1.opcode = x.opc; bus1.rd = x.rd; bus1.rs1 = x.rs1;
        bus1.rs2 = x.rs2; bus1.funct3 = x.f3; bus1.funct7 = x.f7; bus1.imm = x.imm;
        bus1.in_valid = 1'b1;
    endtask

    task automatic drive2(input vec_t x);
        bus2.fmt = x.fmt; bus2.opcode = x.opc; bus2.rd = x.rd; bus2.rs1 = x.rs1;
        bus2.rs2 = x.rs2; bus2.funct3 = x.f3; bus2.funct7 = x.f7; bus2.imm = x.imm;
        bus2.in_valid = 1'b1;
    endtask

    task automatic show(input string tag, input int idx, input logic [31:0] ins);
        $display("xfer %s[%0d] instr=%h", tag, idx, ins);
    endtask

    initial begin
        int errs_seen;
        int cnt2;
        v[0] = '{3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFF_FFFF, 32'hFFF0_0093, 1'b0, 1'b0};
        v[1] = '{3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'h00, 32'h0000_0008, 32'h0020_A423, 1'b0, 1'b0};
        v[2] = '{3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFF_FFFC, 32'hFE00_0EE3, 1'b0, 1'b0};
        v[3] = '{3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'h00, 32'h1234_5000, 32'h1234_52B7, 1'b0, 1'b0};
        v[4] = '{3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'h0000_0800, 32'h0010_00EF, 1'b0, 1'b0};
        v[5] = '{3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'hDEAD_BEEF, 32'h4020_81B3, 1'b0, 1'b0};
        v[6] = '{3'd6, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'h0000_0801, 32'h0000_0000, 1'b0, 1'b1};
        v[7] = '{3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'h0000_0800, 32'h8000_0093, 1'b1, 1'b0};
        v[8] = '{3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'h0000_0003, 32'h0000_0163, 1'b1, 1'b0};
        v[9] = '{3'd4, 7'h37, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'h0000_1001, 32'h0000_1037, 1'b1, 1'b0};
        va   = '{3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'h0000_0001, 32'h0010_0093, 1'b0, 1'b0};
        vb   = '{3'd1, 7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 7'h00, 32'h0000_0002, 32'h0020_0113, 1'b0, 1'b0};
        vc   = '{3'd1, 7'h13, 5'd3, 5'd0, 5'd0, 3'd0, 7'h00, 32'h0000_0003, 32'h0030_0193, 1'b0, 1'b0};
        w[0] = '{3'd4, 7'h37, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'h0000_1001, 32'h0000_1037, 1'b0, 1'b0};
        for (int i = 1; i < 6; i++)
            w[i] = '{3'd7, 7'h13, 5'd1, 5'd2, 5'd3, 3'd1, 7'h01, 32'h0000_0004, 32'h0000_0000, 1'b0, 1'b1};

        bus1.in_valid = 1'b0; bus1.out_ready = 1'b1;
        bus1.fmt = 3'd0; bus1.opcode = 7'd0; bus1.rd = 5'd0; bus1.rs1 = 5'd0; bus1.rs2 = 5'd0;
        bus1.funct3 = 3'd0; bus1.funct7 = 7'd0; bus1.imm = 32'd0;
        bus2.in_valid = 1'b0; bus2.out_ready = 1'b1;
        bus2.fmt = 3'd0; bus2.opcode = 7'd0; bus2.rd = 5'd0; bus2.rs1 = 5'd0; bus2.rs2 = 5'd0;
        bus2.funct3 = 3'd0; bus2.funct7 = 7'd0; bus2.imm = 32'd0;

        // Reset state
        @(negedge clk);
        chk("rst_out_valid", {31'd0, bus1.out_valid}, 32'd0);
        chk("rst_instr", bus1.instr, 32'd0);
        chk("rst_imm_err", {31'd0, bus1.imm_err}, 32'd0);
        chk("rst_fmt_err", {31'd0, bus1.fmt_err}, 32'd0);
        chk("rst_err_cnt", {24'd0, bus1.err_cnt}, 32'd0);
        chk("rst_in_ready", {31'd0, bus1.in_ready}, 32'd1);
        chk("rst_err_cnt2", {30'd0, bus2.err_cnt}, 32'd0);
        aresetn = 1'b1;

        // Streamed formats and immediate errors, one word per cycle
        errs_seen = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            chk($sformatf("stream_in_ready[%0d]", c), {31'd0, bus1.in_ready}, 32'd1);
            if (c == 1) chk("latency_not_yet", {31'd0, bus1.out_valid}, 32'd0);
            if (c >= 2) begin
                chk($sformatf("stream_valid[%0d]", c - 2), {31'd0, bus1.out_valid}, 32'd1);
                chk($sformatf("stream_instr[%0d]", c - 2), bus1.instr, v[c-2].ins);
                chk($sformatf("stream_imm_err[%0d]", c - 2), {31'd0, bus1.imm_err}, {31'd0, v[c-2].ie});
                chk($sformatf("stream_fmt_err[%0d]", c - 2), {31'd0, bus1.fmt_err}, {31'd0, v[c-2].fe});
                chk($sformatf("stream_err_cnt[%0d]", c - 2), {24'd0, bus1.err_cnt}, errs_seen);
                show("stream", c - 2, bus1.instr);
                if (v[c-2].ie || v[c-2].fe) errs_seen++;
            end
            if (c < 10) drive1(v[c]);
            else bus1.in_valid = 1'b0;
        end
        @(negedge clk);
        chk("stream_drained", {31'd0, bus1.out_valid}, 32'd0);
        chk("stream_err_total", {24'd0, bus1.err_cnt}, 32'd4);

        // Backpressure: two words buffer, third is held off
        bus1.out_ready = 1'b0;
        drive1(va);
        @(negedge clk);
        chk("bp_ready_w2", {31'd0, bus1.in_ready}, 32'd1);
        drive1(vb);
        @(negedge clk);
        chk("bp_valid", {31'd0, bus1.out_valid}, 32'd1);
        chk("bp_instr_w1", bus1.instr, va.ins);
        chk("bp_full", {31'd0, bus1.in_ready}, 32'd0);
        drive1(vc);
        @(negedge clk);
        chk("bp_still_full", {31'd0, bus1.in_ready}, 32'd0);
        chk("bp_instr_stable", bus1.instr, va.ins);
        show("bp", 0, bus1.instr);
        bus1.out_ready = 1'b1;
        #1;
        chk("bp_ready_comb", {31'd0, bus1.in_ready}, 32'd1);
        @(negedge clk);
        bus1.in_valid = 1'b0;
        chk("bp_valid_w2", {31'd0, bus1.out_valid}, 32'd1);
        chk("bp_instr_w2", bus1.instr, vb.ins);
        show("bp", 1, bus1.instr);
        @(negedge clk);
        chk("bp_valid_w3", {31'd0, bus1.out_valid}, 32'd1);
        chk("bp_instr_w3", bus1.instr, vc.ins);
        show("bp", 2, bus1.instr);
        @(negedge clk);
        chk("bp_no_dup", {31'd0, bus1.out_valid}, 32'd0);

        // Reset mid-stream with two words in flight
        drive1(v[7]);
        @(negedge clk);
        drive1(v[8]);
        @(negedge clk);
        bus1.in_valid = 1'b0;
        chk("mid_inflight", {31'd0, bus1.out_valid}, 32'd1);
        #2 aresetn = 1'b0;
        #1;
        chk("mid_rst_valid", {31'd0, bus1.out_valid}, 32'd0);
        chk("mid_rst_err_cnt", {24'd0, bus1.err_cnt}, 32'd0);
        chk("mid_rst_instr", bus1.instr, 32'd0);
        chk("mid_rst_in_ready", {31'd0, bus1.in_ready}, 32'd1);
        #1 aresetn = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk($sformatf("mid_no_stale[%0d]", c), {31'd0, bus1.out_valid}, 32'd0);
        end
        drive1(v[3]);
        @(negedge clk);
        bus1.in_valid = 1'b0;
        chk("mid_first_latency", {31'd0, bus1.out_valid}, 32'd0);
        @(negedge clk);
        chk("mid_first_valid", {31'd0, bus1.out_valid}, 32'd1);
        chk("mid_first_instr", bus1.instr, v[3].ins);
        chk("mid_first_err_cnt", {24'd0, bus1.err_cnt}, 32'd0);
        show("mid", 0, bus1.instr);
        @(negedge clk);
        chk("mid_single", {31'd0, bus1.out_valid}, 32'd0);

        // Saturating 2-bit counter, immediate check disabled
        cnt2 = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (c >= 2) begin
                chk($sformatf("sat_valid[%0d]", c - 2), {31'd0, bus2.out_valid}, 32'd1);
                chk($sformatf("sat_instr[%0d]", c - 2), bus2.instr, w[c-2].ins);
                chk($sformatf("sat_imm_err[%0d]", c - 2), {31'd0, bus2.imm_err}, 32'd0);
                chk($sformatf("sat_fmt_err[%0d]", c - 2), {31'd0, bus2.fmt_err}, {31'd0, w[c-2].fe});
                chk($sformatf("sat_cnt[%0d]", c - 2), {30'd0, bus2.err_cnt}, cnt2);
                show("sat", c - 2, bus2.instr);
                if (w[c-2].fe && cnt2 < 3) cnt2++;
            end
            if (c < 6) drive2(w[c]);
            else bus2.in_valid = 1'b0;
        end
        @(negedge clk);
        chk("sat_final", {30'd0, bus2.err_cnt}, 32'd3);
        repeat (3) @(negedge clk);
        chk("sat_holds", {30'd0, bus2.err_cnt}, 32'd3);
        chk("sat_drained", {31'd0, bus2.out_valid}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/riscv_instr_enc.md
Name: riscv_instr_enc

Overview:
- Instruction encoder: the inverse of the immediate generator. Packs opcode, register and funct fields plus a 32-bit immediate into a 32-bit RV32I instruction word, in one of the R/I/S/B/U/J formats.
- Two-stage valid/ready pipeline with backpressure.
- Flags immediates the selected format cannot represent, and keeps a saturating error count.
- Used by stimulus generators and the boot-ROM builder to produce legal instruction streams.

Parameters:
- CHECK_IMM, 1, when 1 the immediate representability check is enabled; when 0, imm_err is tied 0.
- ERR_CNT_W, 8, width of the saturating error counter.

Ports:
- clk  in  1  clock; all registers update on the rising edge.
- aresetn  in  1  asynchronous active-low reset.
- in_valid  in  1  input request valid.
- in_ready  out  1  encoder can accept this cycle.
- fmt  in  3  format: 0=R 1=I 2=S 3=B 4=U 5=J; 6 and 7 are illegal.
- opcode  in  7  instr[6:0].
- rd  in  5  destination register.
- rs1  in  5  source register 1.
- rs2  in  5  source register 2.
- funct3  in  3  funct3 field.
- funct7  in  7  funct7 field (R format only).
- imm  in  32  full signed (or U-type upper) immediate value.
- out_valid  out  1  encoded word valid.
- out_ready  in  1  downstream accepts.
- instr  out  32  encoded instruction.
- imm_err  out  1  immediate not representable in fmt, qualified by out_valid.
- fmt_err  out  1  fmt value 6 or 7, qualified by out_valid.
- err_cnt  out  ERR_CNT_W  count of transferred words with imm_err or fmt_err.

Behaviour:
- Reset (aresetn=0, asynchronous): out_valid=0, both internal stage-valid flags=0, instr=0, imm_err=0, fmt_err=0, err_cnt=0. in_ready=1 while in reset.
- A reset asserted mid-operation discards all in-flight words. The first accept after release is the first output.
- Handshake: a transfer occurs when valid and ready are both 1 on a clock edge.
  - out_valid, once asserted, holds together with a stable instr/imm_err/fmt_err until out_ready.
  - in_ready does not depend on in_valid.
- Pipeline:
  - s2_load = !s2_valid || out_ready.
  - s1_load = !s1_valid || s2_load.
  - in_ready = s1_load. This is a combinational path from out_ready, which is permitted.
  - Stage 1 registers the raw fields. Stage 2 registers the encoded word and the flags.
- Latency: 2 cycles from input accept to out_valid with no stall. Sustained throughput is 1 word per cycle. Two words are buffered under stall.
- Encoding (bit concatenation, MSB first):
  - R: funct7, rs2, rs1, funct3, rd, opcode.
  - I: imm[11:0], rs1, funct3, rd, opcode.
  - S: imm[11:5], rs2, rs1, funct3, imm[4:0], opcode.
  - B: imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode.
  - U: imm[31:12], rd, opcode.
  - J: imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode.
  - Illegal fmt: instr=0x00000000 and fmt_err=1.
- imm_err rules:
  - I and S: imm[31:11] not all equal.
  - B: imm[0]=1, or imm[31:12] not all equal.
  - J: imm[0]=1, or imm[31:20] not all equal.
  - U: imm[11:0] != 0.
  - R: never.
  - Illegal fmt: imm_err=0.
- On error the word is still encoded from the truncated bits. The encoder never drops or stalls on an error.
- err_cnt increments by 1 on each output transfer with imm_err or fmt_err set. It saturates at 2^ERR_CNT_W-1 and does not wrap.
- Ordering: output order equals input order. No loss or duplication under any out_ready pattern.

Test Plan:
- Basic formats, out_ready=1, one request per cycle. Each word appears 2 cycles after accept:
  - I: opcode=0x13, rd=1, rs1=0, funct3=0, imm=0xFFFFFFFF -> 0xFFF00093.
  - S: opcode=0x23, funct3=2, rs1=1, rs2=2, imm=8 -> 0x0020A423.
  - B: opcode=0x63, rs1=rs2=0, funct3=0, imm=0xFFFFFFFC -> 0xFE000EE3.
  - U: opcode=0x37, rd=5, imm=0x12345000 -> 0x123452B7.
  - J: opcode=0x6F, rd=1, imm=0x800 -> 0x001000EF.
- R and illegal fmt:
  - opcode=0x33, rd=3, funct3=0, rs1=1, rs2=2, funct7=0x20 -> 0x402081B3, fmt_err=0.
  - fmt=6 -> instr=0, fmt_err=1, err_cnt=1.
- Immediate errors:
  - I imm=0x800 -> instr=0x80000093 (with I fields rd=1, others 0), imm_err=1.
  - B imm=3 -> imm_err=1.
  - U imm=0x1001 -> imm_err=1.
  - err_cnt increments once per error word.
- Backpressure: out_ready=0, offer 3 words.
  - 2 words are accepted; in_ready=0 and the 3rd is held; out_valid=1 with word 1 stable.
  - Release out_ready -> words 1, 2, 3 appear in order, no duplicates.
- Saturation: with ERR_CNT_W=2, send 5 fmt=7 words -> err_cnt=3 and stays 3.
- Reset mid-stream: 2 words in flight, pulse aresetn low between clock edges -> out_valid=0 and err_cnt=0 immediately; no stale word appears after release.
